param_updown_counter: RTL and testbench



---
 rtl/param_updown_counter.sv | 98 +++++++++
 tb/tb_param_updown_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// Parametrised up/down event counter.
// Adds programmable step, modulo limit, synchronous load and wrap/saturate mode,
// plus a registered terminal-count pulse and sticky overflow/underflow flags.
// With default parameters, up=1 and load=0 it is a plain 4-bit enable counter.
// Reset is synchronous and active-low. All outputs come straight from flops.
module param_updown_counter #(
  parameter int unsigned     WIDTH    = 4,     // 2..32
  parameter longint unsigned MAX_VAL  = 15,    // 1..2^WIDTH-1, modulus is MAX_VAL+1
  parameter longint unsigned STEP     = 1,     // 1..MAX_VAL
  parameter bit              SATURATE = 1'b0   // 0: wrap, 1: clamp at 0 / MAX_VAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  // One extra bit keeps out+STEP and out+MAX_VAL+1 from truncating.
  localparam int unsigned    XW     = WIDTH + 1;
  localparam logic [WIDTH:0] MAX_X  = XW'(MAX_VAL);
  localparam logic [WIDTH:0] MOD_X  = XW'(MAX_VAL + 1);
  localparam logic [WIDTH:0] STEP_X = XW'(STEP);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH:0]   out_x;
  logic [WIDTH:0]   lv_x;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   nxt_x;

  // Next-state: load beats count beats hold; crossings raise tc and a sticky flag.
  always_comb begin
    out_x = {1'b0, out_q};
    lv_x  = {1'b0, load_val};
    sum_x = out_x + STEP_X;
    nxt_x = out_x;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    unf_d = unf_q;

    if (load) begin
      nxt_x = (lv_x > MAX_X) ? MAX_X : lv_x;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (count) begin
      if (up) begin
        if (sum_x > MAX_X) begin
          nxt_x = SATURATE ? MAX_X : (sum_x - MOD_X);
          ovf_d = 1'b1;
          tc_d  = 1'b1;
        end else begin
          nxt_x = sum_x;
        end
      end else begin
        if (out_x >= STEP_X) begin
          nxt_x = out_x - STEP_X;
        end else begin
          // out < STEP here, so out + MOD - STEP stays within 0..MAX_VAL.
          nxt_x = SATURATE ? '0 : (out_x + MOD_X - STEP_X);
          unf_d = 1'b1;
          tc_d  = 1'b1;
        end
      end
    end

    out_d = WIDTH'(nxt_x);
  end

  // State register with synchronous active-low reset overriding load and count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign out = out_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter. Three builds share one stimulus:
// defaults, a modulo-10 step-3 wrapping build, and a saturating step-4 build.
module tb_param_updown_counter;

  logic       clk;
  logic       reset;
  logic       count;
  logic       up;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] d_out, m_out, s_out;
  logic       d_tc, d_ovf, d_unf;
  logic       m_tc, m_ovf, m_unf;
  logic       s_tc, s_ovf, s_unf;

  int checks = 0;
  int errors = 0;

  param_updown_counter u_def (
    .clk(clk), .reset(reset), .count(count), .up(up), .load(load), .load_val(load_val),
    .out(d_out), .tc(d_tc), .ovf(d_ovf), .unf(d_unf)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(1'b0)) u_m9 (
    .clk(clk), .reset(reset), .count(count), .up(up), .load(load), .load_val(load_val),
    .out(m_out), .tc(m_tc), .ovf(m_ovf), .unf(m_unf)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(15), .STEP(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .count(count), .up(up), .load(load), .load_val(load_val),
    .out(s_out), .tc(s_tc), .ovf(s_ovf), .unf(s_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; count = 1'b0; load = 1'b0; up = 1'b1;
    tick();
    reset = 1'b1;
  endtask

  int m_out_exp[7] = '{3, 6, 9, 2, 5, 8, 1};
  int m_tc_exp[7]  = '{0, 0, 0, 1, 0, 0, 1};
  int s_dn_out[5]  = '{11, 7, 3, 0, 0};
  int s_dn_tc[5]   = '{0, 0, 0, 1, 1};
  int z_up[6]      = '{1, 1, 0, 0, 1, 1};
  int z_out[6]     = '{1, 2, 1, 0, 1, 2};

  initial begin
    reset = 1'b0; count = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;

    // Reset held two cycles.
    tick(); tick();
    chk("rst_out", int'(d_out), 0);
    chk("rst_tc",  int'(d_tc),  0);
    chk("rst_ovf", int'(d_ovf), 0);
    chk("rst_unf", int'(d_unf), 0);

    // Default build counts 1..15,0,1; tc only on the wrap to 0.
    reset = 1'b1; count = 1'b1; up = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("up_out", int'(d_out), i % 16);
      chk("up_tc",  int'(d_tc),  (i == 16) ? 1 : 0);
      chk("up_ovf", int'(d_ovf), (i >= 16) ? 1 : 0);
    end

    // Pause at 5 for three cycles, resume, then reset mid-count.
    do_reset();
    count = 1'b1; up = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_hold", int'(d_out), 5);
    count = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_out", int'(d_out), 5);
      chk("hold_tc",  int'(d_tc),  0);
    end
    count = 1'b1;
    tick(); chk("resume6", int'(d_out), 6);
    tick(); chk("resume7", int'(d_out), 7);
    tick(); tick();
    chk("at9", int'(d_out), 9);
    reset = 1'b0;
    tick();
    chk("midrst_out", int'(d_out), 0);
    chk("midrst_ovf", int'(d_ovf), 0);

    // Modulo-10, step 3 build: wrap up, then wrap down from 1.
    reset = 1'b1; count = 1'b1; up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("m9_out", int'(m_out), m_out_exp[i]);
      chk("m9_tc",  int'(m_tc),  m_tc_exp[i]);
    end
    chk("m9_ovf", int'(m_ovf), 1);
    chk("m9_unf0", int'(m_unf), 0);
    up = 1'b0;
    tick();
    chk("m9_dn_out", int'(m_out), 8);
    chk("m9_dn_tc",  int'(m_tc),  1);
    chk("m9_dn_unf", int'(m_unf), 1);

    // Saturating step 4 build: load 14, clamp at 15, then clamp at 0.
    do_reset();
    load = 1'b1; load_val = 4'd14;
    tick();
    chk("sat_load", int'(s_out), 14);
    load = 1'b0; count = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_up_out", int'(s_out), 15);
      chk("sat_up_tc",  int'(s_tc),  1);
    end
    chk("sat_ovf", int'(s_ovf), 1);
    up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_dn_out", int'(s_out), s_dn_out[i]);
      chk("sat_dn_tc",  int'(s_tc),  s_dn_tc[i]);
      chk("sat_dn_unf", int'(s_unf), (i >= 3) ? 1 : 0);
    end

    // Load beats count and clears sticky flags; load above MAX_VAL clamps.
    do_reset();
    count = 1'b1; up = 1'b0;
    tick();
    chk("pre_ld_out", int'(d_out), 15);
    chk("pre_ld_unf", int'(d_unf), 1);
    load = 1'b1; load_val = 4'd7; up = 1'b1;
    tick();
    chk("ld_out", int'(d_out), 7);
    chk("ld_unf", int'(d_unf), 0);
    chk("ld_ovf", int'(d_ovf), 0);
    chk("ld_tc",  int'(d_tc),  0);
    load_val = 4'd13;
    tick();
    chk("ld13_def", int'(d_out), 13);
    chk("ld13_m9",  int'(m_out), 9);

    // Reset beats load.
    reset = 1'b0; load = 1'b1; load_val = 4'd7;
    tick();
    chk("rst_vs_ld", int'(d_out), 0);

    // Direction flips every two cycles with no crossings.
    reset = 1'b1; load = 1'b0; count = 1'b1;
    for (int i = 0; i < 6; i++) begin
      up = z_up[i][0];
      tick();
      chk("zig_out", int'(d_out), z_out[i]);
      chk("zig_tc",  int'(d_tc),  0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
